pipeline_if: RTL and testbench

Instruction-fetch (IF) stage of the 5-stage pipeline. It owns the PC register and the request/response handshake to instruction memory. It absorbs memory latency in a 2-entry fetch buffer and presents one instruction per cycle to ID. It consumes the redirect outputs of EXE (branch mispredict or jalr target) and of ID (static-branch-predictor taken), discarding stale in-flight fetches on every redirect.

---
 rtl/pipeline_if.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_if.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_if.sv
// Instruction-fetch stage: PC register, imem request/response handshake, 2-entry fetch buffer.
// Optional feature macro IF_ALIGN_CHECK_EN: misaligned redirect targets halt fetch and emit one marked nop.
module pipeline_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirection_e_i,
  input  logic [31:0] redirection_pc_e_i,
  input  logic        taken_d_i,
  input  logic [31:0] prediction_pc_d_i,
  input  logic        stall_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        valid_f_o,
  output logic [31:0] instr_f_o,
  output logic [31:0] pc_f_o,
  output logic [31:0] pc_plus4_f_o,
  output logic        instr_misaligned_f_o
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {AL_RUN, AL_PEND, AL_HALT} align_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        mis;
  } out_t;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  inflight_q, inflight_d;
  logic [1:0]  discard_q, discard_d;
  logic [1:0]  tag_cnt_q, tag_cnt_d;
  logic [31:0] tag_q [2];
  logic [31:0] tag_d [2];
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;
  fetch_t      fifo_q [2];
  fetch_t      fifo_d [2];
  out_t        out_q, out_d;
  align_e      align_q, align_d;

  logic        redirect, halted, credit_ok, accept, keep, pop;
  logic [31:0] target_raw, target;
  logic        target_mis;
  fetch_t      rsp;

  assign redirect   = redirection_e_i | taken_d_i;
  assign target_raw = redirection_e_i ? redirection_pc_e_i : prediction_pc_d_i;
`ifdef IF_ALIGN_CHECK_EN
  assign target     = target_raw;
  assign target_mis = |target_raw[1:0];
`else
  assign target     = target_raw & ~32'h3;
  assign target_mis = 1'b0;
`endif

  // Stale in-flight fetches still occupy credit until their responses drain.
  assign credit_ok   = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < 3'd2;
  assign halted      = (align_q != AL_RUN);
  assign imem_req_o  = resetn & ~redirect & ~halted & credit_ok;
  assign imem_addr_o = pc_q;
  assign accept      = imem_req_o & imem_gnt_i;
  assign keep        = imem_rvalid_i & (discard_q == 2'd0) & ~redirect;
  assign rsp         = '{pc: tag_q[0], instr: imem_rdata_i};

  function automatic out_t present(input fetch_t f, input logic mis);
    out_t o;
    o.valid = 1'b1;
    o.instr = f.instr;
    o.pc    = f.pc;
    o.pc4   = f.pc + 32'd4;
    o.mis   = mis;
    return o;
  endfunction

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q + {1'b0, accept} - {1'b0, imem_rvalid_i};
    discard_d  = discard_q;
    tag_cnt_d  = tag_cnt_q;
    tag_d      = tag_q;
    fifo_cnt_d = fifo_cnt_q;
    fifo_d     = fifo_q;
    out_d      = out_q;
    align_d    = align_q;
    pop        = 1'b0;

    if (redirect)    pc_d = target;
    else if (accept) pc_d = pc_q + 32'd4;

    if (redirect)                                    discard_d = inflight_q - {1'b0, imem_rvalid_i};
    else if (imem_rvalid_i && discard_q != 2'd0)     discard_d = discard_q - 2'd1;

    // Tags of discarded fetches are dropped wholesale at the redirect.
    if (redirect) begin
      tag_cnt_d = '0;
    end else begin
      if (keep) begin
        tag_d[0]  = tag_q[1];
        tag_cnt_d = tag_cnt_q - 2'd1;
      end
      if (accept) begin
        tag_d[tag_cnt_d[0]] = pc_q;
        tag_cnt_d           = tag_cnt_d + 2'd1;
      end
    end

    if (redirect) begin
      fifo_cnt_d  = '0;
      out_d.valid = 1'b0;
      out_d.mis   = 1'b0;
      align_d     = target_mis ? AL_PEND : AL_RUN;
    end else begin
      if (!stall_i) begin
        if (fifo_cnt_q != 2'd0) begin
          out_d = present(fifo_q[0], 1'b0);
          pop   = 1'b1;
        end else if (keep) begin
          out_d = present(rsp, 1'b0);
        end else if (align_q == AL_PEND && inflight_q == 2'd0) begin
          out_d   = present('{pc: pc_q, instr: NOP}, 1'b1);
          align_d = AL_HALT;
        end else begin
          out_d.valid = 1'b0;
          out_d.mis   = 1'b0;
        end
      end
      if (pop) begin
        fifo_d[0]  = fifo_q[1];
        fifo_cnt_d = fifo_cnt_q - 2'd1;
      end
      if (keep && (stall_i || fifo_cnt_q != 2'd0)) begin
        fifo_d[fifo_cnt_d[0]] = rsp;
        fifo_cnt_d            = fifo_cnt_d + 2'd1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      tag_cnt_q  <= '0;
      fifo_cnt_q <= '0;
      // NOTE: the tiny tag/fifo arrays are reset as well, keeping X off the outputs after reset.
      tag_q      <= '{default: '0};
      fifo_q     <= '{default: '0};
      out_q      <= '0;
      align_q    <= AL_RUN;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      tag_cnt_q  <= tag_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      tag_q      <= tag_d;
      fifo_q     <= fifo_d;
      out_q      <= out_d;
      align_q    <= align_d;
    end
  end

  assign valid_f_o            = out_q.valid;
  assign instr_f_o            = out_q.instr;
  assign pc_f_o               = out_q.pc;
  assign pc_plus4_f_o         = out_q.pc4;
  assign instr_misaligned_f_o = out_q.mis;
endmodule

// File: tb/tb_pipeline_if.sv
// Self-checking bench for pipeline_if: memory responder with variable latency, output scoreboard,
// table-driven redirect vectors and hand-written stall / latency / wrap / reset sequences.
module tb_pipeline_if;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        redirection_e_i, taken_d_i, stall_i;
  logic [31:0] redirection_pc_e_i, prediction_pc_d_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        valid_f_o, instr_misaligned_f_o;
  logic [31:0] instr_f_o, pc_f_o, pc_plus4_f_o;

  always #5 clk = ~clk;

  pipeline_if #(.RESET_PC(RPC)) dut (
    .clk(clk), .resetn(resetn),
    .redirection_e_i(redirection_e_i), .redirection_pc_e_i(redirection_pc_e_i),
    .taken_d_i(taken_d_i), .prediction_pc_d_i(prediction_pc_d_i),
    .stall_i(stall_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .valid_f_o(valid_f_o), .instr_f_o(instr_f_o), .pc_f_o(pc_f_o),
    .pc_plus4_f_o(pc_plus4_f_o), .instr_misaligned_f_o(instr_misaligned_f_o)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // ---------------- memory responder ----------------
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc     = 0;
  int    mem_lat = 1;
  bit    gnt_en  = 1'b1;

  assign imem_gnt_i = imem_req_o & gnt_en;
  always @(posedge clk) cyc++;

  always begin
    @(negedge clk); #1;
    if (!resetn) begin
      mq.delete();
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
      end
      if (imem_req_o && imem_gnt_i) mq.push_back('{addr: imem_addr_o, due: cyc + mem_lat});
    end
  end

  // ---------------- output scoreboard ----------------
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } exp_t;
  exp_t        sb[$];
  exp_t        e;
  logic [31:0] last_pc = '0;
  bit          mon_st;

  always begin
    @(posedge clk); mon_st = stall_i;
    @(negedge clk); #1;
    if (resetn && valid_f_o && !mon_st) begin
      if (sb.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL sb_underflow: unexpected instr at pc %h, expected none", pc_f_o);
      end else begin
        e = sb.pop_front();
        check("sb_pc",    pc_f_o,       e.pc);
        check("sb_pc4",   pc_plus4_f_o, e.pc + 32'd4);
        check("sb_instr", instr_f_o,    e.instr);
        check("sb_mis",   32'(instr_misaligned_f_o), 32'(e.mis));
        last_pc = e.pc;
      end
    end
  end

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++)
      sb.push_back('{pc: start + 32'(4 * i), instr: mem_word(start + 32'(4 * i)), mis: 1'b0});
  endtask

  // Drives a one-cycle redirect in cycle N; returns at the start of N+1 with the scoreboard reloaded.
  task automatic do_redirect(input bit use_e, input logic [31:0] e_pc, input bit use_d,
                             input logic [31:0] d_pc, input logic [31:0] exp_t_pc, input bit mis);
    @(negedge clk);
    redirection_e_i = use_e; redirection_pc_e_i = e_pc;
    taken_d_i       = use_d; prediction_pc_d_i  = d_pc;
    @(negedge clk);
    redirection_e_i = 1'b0; taken_d_i = 1'b0;
    sb.delete();
    if (mis) sb.push_back('{pc: exp_t_pc, instr: 32'h0000_0013, mis: 1'b1});
    else     push_seq(exp_t_pc, 64);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (valid_f_o) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    bit use_e; logic [31:0] e_pc; bit use_d; logic [31:0] d_pc; logic [31:0] exp_pc;
  } vec_t;
  vec_t vt[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int bad;

    vt[0] = '{1'b1, 32'h0000_2000, 1'b0, 32'h0,         32'h0000_2000};
    vt[1] = '{1'b0, 32'h0,         1'b1, 32'h0000_0400, 32'h0000_0400};
    vt[2] = '{1'b1, 32'h0000_0800, 1'b1, 32'h0000_0400, 32'h0000_0800};
    vt[3] = '{1'b0, 32'h0,         1'b1, 32'h0000_3FFC, 32'h0000_3FFC};
    vt[4] = '{1'b1, 32'h0000_0040, 1'b1, 32'h0000_0044, 32'h0000_0040};

    resetn = 1'b0; stall_i = 1'b0;
    redirection_e_i = 1'b0; redirection_pc_e_i = '0;
    taken_d_i = 1'b0; prediction_pc_d_i = '0;
    push_seq(RPC, 64);

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    check("rst_req",   32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(valid_f_o), 32'd0);
    check("rst_instr", instr_f_o, 32'd0);
    check("rst_pc",    pc_f_o, 32'd0);
    check("rst_pc4",   pc_plus4_f_o, 32'd0);
    check("rst_mis",   32'(instr_misaligned_f_o), 32'd0);

    // Release: consecutive fetch addresses, first output two cycles after first request
    @(negedge clk); resetn = 1'b1; #2;
    check("c0_req",  32'(imem_req_o), 32'd1);
    check("c0_addr", imem_addr_o, RPC);
    @(negedge clk); #2;
    check("c1_addr",  imem_addr_o, RPC + 32'd4);
    check("c1_valid", 32'(valid_f_o), 32'd0);
    @(negedge clk); #2;
    check("c2_addr",  imem_addr_o, RPC + 32'd8);
    check("c2_valid", 32'(valid_f_o), 32'd1);
    check("c2_pc",    pc_f_o, RPC);
    check("c2_pc4",   pc_plus4_f_o, RPC + 32'd4);
    repeat (4) @(negedge clk);

    // Redirect table: req to target in N+1, valid with target in N+3
    for (int i = 0; i < 5; i++) begin
      do_redirect(vt[i].use_e, vt[i].e_pc, vt[i].use_d, vt[i].d_pc, vt[i].exp_pc, 1'b0);
      #2;
      check($sformatf("v%0d_req", i),  32'(imem_req_o), 32'd1);
      check($sformatf("v%0d_addr", i), imem_addr_o, vt[i].exp_pc);
      repeat (2) @(negedge clk);
      #2;
      check($sformatf("v%0d_valid", i), 32'(valid_f_o), 32'd1);
      check($sformatf("v%0d_pc", i),    pc_f_o, vt[i].exp_pc);
      repeat (3) @(negedge clk);
    end

    // PC wrap
    do_redirect(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'hFFFF_FFFC, 1'b0);
    #2; check("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    @(negedge clk); #2; check("wrap_addr1", imem_addr_o, 32'h0000_0000);
    repeat (5) @(negedge clk);

    // Stall for 4 cycles: outputs hold, request drops once credit is exhausted
    @(negedge clk); stall_i = 1'b1; #2;
    check("stall0_pc", pc_f_o, last_pc);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #2;
      check($sformatf("stall%0d_req", i),   32'(imem_req_o), 32'd0);
      check($sformatf("stall%0d_valid", i), 32'(valid_f_o), 32'd1);
      check($sformatf("stall%0d_pc", i),    pc_f_o, last_pc);
    end
    @(negedge clk); stall_i = 1'b0;
    repeat (8) @(negedge clk);

    // Grant withheld: request and address held stable
    gnt_en = 1'b0;
    do_redirect(1'b1, 32'h0000_3000, 1'b0, 32'h0, 32'h0000_3000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #2;
      check($sformatf("hold%0d_req", i),  32'(imem_req_o), 32'd1);
      check($sformatf("hold%0d_addr", i), imem_addr_o, 32'h0000_3000);
      @(negedge clk);
    end
    gnt_en = 1'b1;
    repeat (6) @(negedge clk);

    // 3-cycle latency, redirect with two fetches in flight
    mem_lat = 3;
    do_redirect(1'b1, 32'h0000_5000, 1'b0, 32'h0, 32'h0000_5000, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #2;
      if (mq.size() == 2) begin ok = 1'b1; break; end
    end
    check("lat_two_inflight", 32'(ok), 32'd1);
    do_redirect(1'b1, 32'h0000_2000, 1'b0, 32'h0, 32'h0000_2000, 1'b0);
    wait_valid(20, ok);
    check("lat_valid_seen", 32'(ok), 32'd1);
    check("lat_first_pc",   pc_f_o, 32'h0000_2000);
    check("lat_first_instr", instr_f_o, mem_word(32'h0000_2000));
    repeat (10) @(negedge clk);
    mem_lat = 1;
    repeat (4) @(negedge clk);

`ifdef IF_ALIGN_CHECK_EN
    // Misaligned target: drain, one marked nop, then quiet until next redirect
    mem_lat = 2;
    repeat (4) @(negedge clk);
    do_redirect(1'b1, 32'h0000_1002, 1'b0, 32'h0, 32'h0000_1002, 1'b1);
    #2; check("mis_req_off", 32'(imem_req_o), 32'd0);
    wait_valid(10, ok);
    check("mis_valid_seen", 32'(ok), 32'd1);
    check("mis_pc",    pc_f_o, 32'h0000_1002);
    check("mis_instr", instr_f_o, 32'h0000_0013);
    check("mis_flag",  32'(instr_misaligned_f_o), 32'd1);
    bad = 0;
    repeat (6) begin
      @(negedge clk); #2;
      if (imem_req_o || valid_f_o) bad++;
    end
    check("mis_quiet", 32'(bad), 32'd0);
    mem_lat = 1;
    do_redirect(1'b1, 32'h0000_0600, 1'b0, 32'h0, 32'h0000_0600, 1'b0);
    #2; check("mis_recover_addr", imem_addr_o, 32'h0000_0600);
    repeat (6) @(negedge clk);
`else
    // Without the alignment check the low target bits are forced to zero
    do_redirect(1'b1, 32'h0000_1002, 1'b0, 32'h0, 32'h0000_1000, 1'b0);
    #2; check("mask_addr", imem_addr_o, 32'h0000_1000);
    repeat (2) @(negedge clk); #2;
    check("mask_pc",  pc_f_o, 32'h0000_1000);
    check("mask_mis", 32'(instr_misaligned_f_o), 32'd0);
    repeat (4) @(negedge clk);
`endif

    // Asynchronous reset mid-stream
    @(negedge clk); #3;
    resetn = 1'b0;
    #1;
    check("arst_req",   32'(imem_req_o), 32'd0);
    check("arst_valid", 32'(valid_f_o), 32'd0);
    check("arst_pc",    pc_f_o, 32'd0);
    check("arst_instr", instr_f_o, 32'd0);
    sb.delete();
    push_seq(RPC, 64);
    repeat (2) @(negedge clk);
    resetn = 1'b1; #2;
    check("arst_addr", imem_addr_o, RPC);
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
